// File: rtl/actuator_responder_pkg.sv
// Shared types for the actuator responder: FSM states, Ca command codes
// and the single-bit channel encoding.
package actuator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_MOVE  = 2'b01,
        ST_DONE  = 2'b10,
        ST_FAULT = 2'b11
    } state_e;

    localparam logic [1:0] CMD_IDLE = 2'b00;
    localparam logic [1:0] CMD_CH1  = 2'b01;
    localparam logic [1:0] CMD_CH2  = 2'b10;
    localparam logic [1:0] CMD_DONE = 2'b11;

    // One bit is enough: a single channel register makes motor_o==11 impossible.
    typedef enum logic {
        CH_1 = 1'b0,
        CH_2 = 1'b1
    } chan_e;

    // Command code that started (and must keep) a move on this channel.
    function automatic logic [1:0] chan_cmd(input chan_e ch);
        return (ch == CH_2) ? CMD_CH2 : CMD_CH1;
    endfunction

    // One-hot motor drive for a channel.
    function automatic logic [1:0] chan_motor(input chan_e ch);
        return (ch == CH_2) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/actuator_responder_if.sv
// Command/sense bus between the sequencing controller (master) and the
// plant-side actuator responder (slave).
interface actuator_responder_if;
    logic [1:0] ca_i;
    logic       start_i;
    logic       c1_o;
    logic       c2_o;
    logic       i_o;
    logic [1:0] motor_o;
    logic       busy_o;
    logic       done_o;
    logic       err_o;

    modport master (
        output ca_i, start_i,
        input  c1_o, c2_o, i_o, motor_o, busy_o, done_o, err_o
    );

    modport slave (
        input  ca_i, start_i,
        output c1_o, c2_o, i_o, motor_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/actuator_responder_travel_timer.sv
// Loadable down-counter with a zero flag. Load has priority over enable;
// the count holds at zero rather than wrapping.
module travel_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Count register: load, else decrement toward zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en && (cnt != '0))
            cnt <= cnt - W'(1);
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/actuator_responder.sv
// Plant-side responder for the 2-bit actuator command bus. Runs the
// addressed actuator for TRAVEL_CYCLES cycles and reports sticky
// completion flags plus a synchronised initiate level.
// Optional build macro: ACTUATOR_RESPONDER_TIMEOUT_EN adds an idle
// timeout that forces FAULT when a completed plant sits on an unchanged
// command for TIMEOUT_CYCLES cycles.
module actuator_responder
    import actuator_pkg::*;
#(
    parameter int TRAVEL_CYCLES  = 8,
    parameter int CNT_W          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst_n,
    actuator_responder_if.slave bus
);

    // Counter is loaded with N-1 and the move ends on the edge that sees zero,
    // which keeps the motor on for exactly TRAVEL_CYCLES cycles.
    localparam logic [CNT_W-1:0] TRAVEL_LOAD = CNT_W'(TRAVEL_CYCLES - 1);

    state_e state, state_nx;
    chan_e  ch, ch_nx;
    logic   c1, c2, ini;
    logic   c1_nx, c2_nx, ini_nx;
    logic   clr;
    logic   tr_load, tr_en, tr_zero;
    logic   sync1, sync2, start_prev, start_rise;
    logic   fault_to;

    // Two-flop synchroniser plus edge register for the start button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            start_prev <= 1'b0;
        end else begin
            sync1      <= bus.start_i;
            sync2      <= sync1;
            start_prev <= sync2;
        end
    end

    assign start_rise = sync2 & ~start_prev;

    travel_timer #(.W(CNT_W)) u_travel (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tr_load),
        .load_val (TRAVEL_LOAD),
        .en       (tr_en),
        .zero     (tr_zero)
    );

`ifdef ACTUATOR_RESPONDER_TIMEOUT_EN
    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

    logic [1:0] ca_prev;
    logic       to_run, to_zero;

    // Previous command, used to detect a static bus while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ca_prev <= CMD_IDLE;
        else
            ca_prev <= bus.ca_i;
    end

    // Runs only while idle with a completed channel and an unchanged command;
    // anything else reloads, so it restarts on every change or IDLE exit.
    assign to_run = (state == ST_IDLE) && (c1 || c2) && (bus.ca_i == ca_prev);

    travel_timer #(.W(TO_W)) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (!to_run),
        .load_val (TO_LOAD),
        .en       (to_run),
        .zero     (to_zero)
    );

    assign fault_to = to_run && to_zero;
`else
    // Without the timeout IDLE waits indefinitely.
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign fault_to       = 1'b0;
`endif

    // State, channel and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            ch    <= CH_1;
            c1    <= 1'b0;
            c2    <= 1'b0;
            ini   <= 1'b0;
        end else begin
            state <= state_nx;
            ch    <= ch_nx;
            c1    <= c1_nx;
            c2    <= c2_nx;
            ini   <= ini_nx;
        end
    end

    // Next-state, travel timer control and flag updates.
    always_comb begin
        state_nx = state;
        ch_nx    = ch;
        c1_nx    = c1;
        c2_nx    = c2;
        clr      = 1'b0;
        tr_load  = 1'b0;
        tr_en    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus.ca_i == CMD_CH1 && !c1) begin
                    state_nx = ST_MOVE;
                    ch_nx    = CH_1;
                    tr_load  = 1'b1;
                end else if (bus.ca_i == CMD_CH2 && !c2) begin
                    state_nx = ST_MOVE;
                    ch_nx    = CH_2;
                    tr_load  = 1'b1;
                end else if (bus.ca_i == CMD_DONE) begin
                    state_nx = ST_DONE;
                end else if (fault_to) begin
                    state_nx = ST_FAULT;
                end
            end
            ST_MOVE: begin
                if (bus.ca_i == chan_cmd(ch)) begin
                    if (tr_zero) begin
                        state_nx = ST_IDLE;
                        if (ch == CH_1) c1_nx = 1'b1;
                        else            c2_nx = 1'b1;
                    end else begin
                        tr_en = 1'b1;
                    end
                end else if (bus.ca_i == CMD_IDLE) begin
                    state_nx = ST_IDLE;
                end else begin
                    state_nx = ST_FAULT;
                end
            end
            ST_DONE, ST_FAULT: begin
                if (bus.ca_i == CMD_IDLE) begin
                    state_nx = ST_IDLE;
                    clr      = 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase

        if (clr) begin
            c1_nx = 1'b0;
            c2_nx = 1'b0;
        end

        // Clear beats a coincident start edge.
        if (clr)             ini_nx = 1'b0;
        else if (start_rise) ini_nx = 1'b1;
        else                 ini_nx = ini;
    end

    assign bus.c1_o    = c1;
    assign bus.c2_o    = c2;
    assign bus.i_o     = ini;
    assign bus.motor_o = (state == ST_MOVE) ? chan_motor(ch) : 2'b00;
    assign bus.busy_o  = (state == ST_MOVE);
    assign bus.done_o  = (state == ST_DONE);
    assign bus.err_o   = (state == ST_FAULT);

endmodule

// File: tb/tb_actuator_responder.sv
// Self-checking bench for actuator_responder: directed scenarios plus a
// randomized run, all compared against a behavioural model of the plant.
module tb_actuator_responder;

    localparam int TRAVEL  = 8;
    localparam int TIMEOUT = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    actuator_responder_if bus ();

    actuator_responder #(
        .TRAVEL_CYCLES  (TRAVEL),
        .CNT_W          (4),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 moving, 2 done, 3 fault. m_left = motor cycles still owed.
    int         m_mode = 0;
    int         m_ch   = 0;
    int         m_left = 0;
    int         m_same = 0;
    bit         m_c1 = 0, m_c2 = 0, m_i = 0;
    bit         h1 = 0, h2 = 0, h3 = 0;
    bit         mclr, mrise;
    logic [1:0] m_ca_prev = 2'b00;
    logic [1:0] mca;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_ch = 0; m_left = 0; m_same = 0;
            m_c1 = 0; m_c2 = 0; m_i = 0;
            h1 = 0; h2 = 0; h3 = 0;
            m_ca_prev = 2'b00;
        end else begin
            mca  = bus.ca_i;
            mclr = 0;
            if (!(m_mode == 0 && (m_c1 || m_c2) && mca == m_ca_prev)) m_same = 0;
            case (m_mode)
                0: begin
                    if (mca == 2'd1 && !m_c1) begin
                        m_mode = 1; m_ch = 1; m_left = TRAVEL;
                    end else if (mca == 2'd2 && !m_c2) begin
                        m_mode = 1; m_ch = 2; m_left = TRAVEL;
                    end else if (mca == 2'd3) begin
                        m_mode = 2;
                    end
`ifdef ACTUATOR_RESPONDER_TIMEOUT_EN
                    else if ((m_c1 || m_c2) && mca == m_ca_prev) begin
                        m_same++;
                        if (m_same >= TIMEOUT) m_mode = 3;
                    end
`endif
                end
                1: begin
                    if (int'(mca) == m_ch) begin
                        m_left--;
                        if (m_left == 0) begin
                            if (m_ch == 1) m_c1 = 1; else m_c2 = 1;
                            m_mode = 0;
                        end
                    end else if (mca == 2'd0) m_mode = 0;
                    else m_mode = 3;
                end
                default: if (mca == 2'd0) begin m_mode = 0; mclr = 1; end
            endcase
            mrise = h2 & ~h3;
            h3 = h2; h2 = h1; h1 = bus.start_i;
            if (mclr) begin m_c1 = 0; m_c2 = 0; m_i = 0; end
            else if (mrise) m_i = 1;
            m_ca_prev = mca;
        end
    end

    function automatic logic [7:0] expv();
        logic [1:0] mot;
        mot = (m_mode == 1) ? ((m_ch == 1) ? 2'b01 : 2'b10) : 2'b00;
        return {m_c1, m_c2, m_i, mot, (m_mode == 1), (m_mode == 2), (m_mode == 3)};
    endfunction

    wire [7:0] dutv = {bus.c1_o, bus.c2_o, bus.i_o, bus.motor_o,
                       bus.busy_o, bus.done_o, bus.err_o};

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bus.ca_i = 2'b00; bus.start_i = 1'b0; rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (dutv !== 8'h00) begin errors++; $display("FAIL reset_state dut=%b exp=%b", dutv, 8'h00); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (dutv !== expv()) begin errors++; $display("FAIL reset_release dut=%b exp=%b", dutv, expv()); end
    endtask

    task automatic test_move(input logic [1:0] cmd, input string nm);
        int  on = 0;
        bit  seen = 0;
        logic [7:0] fin;
        bus.ca_i = cmd;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            checks++;
            if (dutv !== expv()) begin errors++; $display("FAIL %s_model t=%0t dut=%b exp=%b", nm, $time, dutv, expv()); end
            if (bus.motor_o == cmd) on++;
            if ((cmd == 2'b01 && bus.c1_o) || (cmd == 2'b10 && bus.c2_o)) begin seen = 1; fin = dutv; end
        end
        checks++;
        if (on != TRAVEL || !seen) begin errors++; $display("FAIL %s_travel motor_cycles=%0d flag=%0d exp %0d,1", nm, on, seen, TRAVEL); end
        checks++;
        if (seen && (fin[4:2] !== 3'b000)) begin errors++; $display("FAIL %s_motor_off motor/busy=%b exp=000", nm, fin[4:2]); end
    endtask

    task automatic test_ch2_and_done();
        test_move(2'b10, "ch2");
        bus.ca_i = 2'b11;
        @(negedge clk);
        checks++;
        if (bus.done_o !== 1'b1 || dutv !== expv()) begin errors++; $display("FAIL done_enter dut=%b exp=%b", dutv, expv()); end
        bus.ca_i = 2'b00;
        @(negedge clk);
        checks++;
        if (dutv !== 8'h00) begin errors++; $display("FAIL done_exit dut=%b exp=%b", dutv, 8'h00); end
    endtask

    task automatic test_fault();
        bus.ca_i = 2'b01;
        repeat (3) @(negedge clk);
        bus.ca_i = 2'b10;
        @(negedge clk);
        checks++;
        if (bus.err_o !== 1'b1 || bus.motor_o !== 2'b00) begin errors++; $display("FAIL fault_enter err=%b motor=%b exp 1,00", bus.err_o, bus.motor_o); end
        bus.ca_i = 2'b00;
        @(negedge clk);
        checks++;
        if (dutv !== 8'h00 || dutv !== expv()) begin errors++; $display("FAIL fault_exit dut=%b exp=%b", dutv, 8'h00); end
    endtask

    task automatic test_abort();
        bus.ca_i = 2'b01;
        repeat (4) @(negedge clk);
        bus.ca_i = 2'b00;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (bus.busy_o !== 1'b0 || bus.c1_o !== 1'b0 || bus.err_o !== 1'b0 || dutv !== expv())
                begin errors++; $display("FAIL abort dut=%b exp=%b", dutv, expv()); end
        end
    endtask

    task automatic test_start();
        bus.start_i = 1'b1;
        repeat (2) @(negedge clk);
        bus.start_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.i_o !== 1'b1) begin errors++; $display("FAIL start_set i=%b exp=1", bus.i_o); end
        repeat (5) @(negedge clk);
        checks++;
        if (bus.i_o !== 1'b1 || dutv !== expv()) begin errors++; $display("FAIL start_hold dut=%b exp=%b", dutv, expv()); end
        // start edge lands on the same clock edge as the DONE exit clear
        bus.ca_i = 2'b11;
        @(negedge clk);
        bus.start_i = 1'b1;
        repeat (2) @(negedge clk);
        bus.ca_i = 2'b00;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (bus.i_o !== 1'b0 || dutv !== expv()) begin errors++; $display("FAIL start_vs_clear dut=%b exp=%b", dutv, expv()); end
        end
        bus.start_i = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            checks++;
            if (dutv !== expv()) begin errors++; $display("FAIL random t=%0t ca=%b dut=%b exp=%b", $time, bus.ca_i, dutv, expv()); end
            if ($urandom_range(99) < 20) bus.ca_i = 2'($urandom_range(3));
            if ($urandom_range(7) == 0) bus.start_i = ~bus.start_i;
        end
        bus.start_i = 1'b0;
    endtask

    task automatic test_async_reset();
        bus.ca_i = 2'b11; @(negedge clk);
        bus.ca_i = 2'b00; @(negedge clk);
        bus.ca_i = 2'b01;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.motor_o !== 2'b01 || dutv !== expv()) begin errors++; $display("FAIL pre_reset_move dut=%b exp=%b", dutv, expv()); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dutv !== 8'h00) begin errors++; $display("FAIL async_reset dut=%b exp=%b", dutv, 8'h00); end
        bus.ca_i = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (dutv !== expv()) begin errors++; $display("FAIL post_reset dut=%b exp=%b", dutv, expv()); end
    endtask

`ifdef ACTUATOR_RESPONDER_TIMEOUT_EN
    task automatic test_timeout();
        int idx = -1;
        bus.ca_i = 2'b01;
        for (int n = 0; n < 100 && !bus.err_o; n++) begin
            @(negedge clk);
            checks++;
            if (dutv !== expv()) begin errors++; $display("FAIL timeout_model t=%0t dut=%b exp=%b", $time, dutv, expv()); end
            if (idx >= 0) idx++;
            else if (bus.c1_o) idx = 0;
        end
        checks++;
        if (bus.err_o !== 1'b1 || idx != TIMEOUT) begin errors++; $display("FAIL timeout err=%b cycles=%0d exp 1,%0d", bus.err_o, idx, TIMEOUT); end
        bus.ca_i = 2'b00;
        @(negedge clk);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_move(2'b01, "ch1");
        test_ch2_and_done();
        test_fault();
        test_abort();
        test_start();
        test_random();
        test_async_reset();
`ifdef ACTUATOR_RESPONDER_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/actuator_responder.md
Name: actuator_responder

Overview:
- Plant-side responder for the 2-bit actuator command bus (Ca) driven by the dual-FSM sequencing controller.
- Accepts commands and runs the addressed actuator for a fixed travel time.
- Returns sensor-style completion levels (c1_o, c2_o) and an initiate level (i_o) to the controller's C1/C2/I inputs.
- Sits in the top-level beside the controller and closes the command/sense loop for bring-up and in-system operation.

Parameters:
- TRAVEL_CYCLES, 8: cycles each actuator is driven per command; legal range 1..2^CNT_W.
- CNT_W, 4: travel counter width.
- TIMEOUT_CYCLES, 64: idle timeout; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ca_i  in  2  command: 00 idle, 01 actuate ch1, 10 actuate ch2, 11 sequence done.
- start_i  in  1  asynchronous start button.
- c1_o  out  1  ch1 travel complete, sticky.
- c2_o  out  1  ch2 travel complete, sticky.
- i_o  out  1  initiate request level.
- motor_o  out  2  actuator drive; bit0 = ch1, bit1 = ch2.
- busy_o  out  1  a move is in progress.
- done_o  out  1  DONE state indication.
- err_o  out  1  FAULT state indication.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: state IDLE, counter 0, all outputs 0, start synchroniser cleared.
- Inputs:
  - ca_i is sampled every rising edge with no extra register stage; the controller drives it from registers.
  - start_i passes through a 2-flop synchroniser plus an edge register.
  - A synchronised rising edge sets i_o. i_o stays set until cleared by the ca_i==00 exit from DONE or FAULT.
- States are IDLE, MOVE, DONE and FAULT. motor_o, busy_o, done_o and err_o are Moore-decoded from state and the channel register.
- IDLE:
  - ca_i==01 with c1_o=0: go to MOVE, ch=1, counter loaded with TRAVEL_CYCLES-1.
  - ca_i==10 with c2_o=0: go to MOVE, ch=2, same counter load.
  - ca_i==01 with c1_o=1, or ca_i==10 with c2_o=1: ignored, stay in IDLE.
  - ca_i==11: go to DONE.
  - ca_i==00: stay in IDLE.
- MOVE:
  - busy_o=1 and motor_o[ch-1]=1.
  - Counter decrements each cycle while ca_i equals the command that started the move.
  - On the edge where the counter is 0: set c1_o or c2_o, then return to IDLE.
  - Latency: motor high for exactly TRAVEL_CYCLES cycles. The c-flag rises on the same edge the motor falls, i.e. TRAVEL_CYCLES cycles after the sampling edge.
  - ca_i==00 during MOVE: abort to IDLE, motor off next cycle, no flag set.
  - ca_i equal to the other channel or 11 during MOVE: go to FAULT, motor off next cycle.
- DONE:
  - done_o=1.
  - ca_i==00: go to IDLE and clear c1_o, c2_o and i_o on that edge.
  - Any other value: stay in DONE.
- FAULT:
  - err_o=1 and motors off.
  - ca_i==00: go to IDLE and clear c1_o, c2_o and i_o.
- Simultaneous events:
  - A start edge in the same cycle as a clear: the clear wins and i_o ends at 0.
  - A start edge is honoured in any state.
- Reset asserted mid-move: motor_o drops asynchronously and the counter is discarded.
- motor_o is never 11, which is guaranteed by the single channel register.

Optional Feature:
- Macro: ACTUATOR_RESPONDER_TIMEOUT_EN.
- Defined:
  - A TIMEOUT counter runs in IDLE whenever (c1_o|c2_o)=1 and ca_i is unchanged.
  - Reaching TIMEOUT_CYCLES forces FAULT.
  - The counter resets on any ca_i change or on leaving IDLE.
- Undefined: no counter is built and IDLE waits indefinitely.

Decomposition:
- Package actuator_pkg:
  - state enum (IDLE, MOVE, DONE, FAULT);
  - command codes CMD_IDLE=00, CMD_CH1=01, CMD_CH2=10, CMD_DONE=11;
  - channel encoding.
- Sub-module travel_timer: loadable down-counter, CNT_W wide, with load/enable inputs and a zero flag. The optional timeout reuses it.

Test Plan:
- Reset, then ca_i=01 held → motor_o=01 for exactly 8 cycles, c1_o=1 on the 8th edge, busy_o low after.
- After c1_o=1, ca_i=10 → motor_o=10 for 8 cycles, then c2_o=1. Then ca_i=11 → done_o=1. Then ca_i=00 → c1_o=c2_o=i_o=0 and state IDLE.
- ca_i=01, switch to 10 after 3 cycles → err_o=1 next cycle, motor_o=00. Then ca_i=00 → IDLE with c-flags clear.
- ca_i=01, drop to 00 after 4 cycles → IDLE, c1_o stays 0, no err_o.
- start_i pulse of 2 cycles → i_o=1 by the 3rd edge and held. A clear coincident with a start edge → i_o=0.
- rst_n low mid-MOVE → all outputs 0 immediately (asynchronously). With ACTUATOR_RESPONDER_TIMEOUT_EN: c1_o set then ca_i static for 64 cycles → err_o=1.
